// File: rtl/jtag_types_pkg.sv
// Shared JTAG types: TAP state encoding (IEEE 1149.1 table codes) and reset constant.
// Used by tap_controller, instruction_reg and the data registers.
package jtag_types_pkg;

  localparam int TAP_STATE_W = 4;

  typedef enum logic [TAP_STATE_W-1:0] {
    TAP_EX2_DR   = 4'h0,
    TAP_EX1_DR   = 4'h1,
    TAP_SH_DR    = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8,
    TAP_EX1_IR   = 4'h9,
    TAP_SH_IR    = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_t;

  localparam tap_state_t TAP_TLR_RESET = TAP_TLR;

endpackage

// File: rtl/tap_tdo_stage.sv
// TDO source mux and driver enable; with JTAG_TDO_NEGEDGE_EN defined the outputs
// are re-timed on the falling edge of TCK, otherwise they are purely combinational.
module tap_tdo_stage
  import jtag_types_pkg::*;
#(
  parameter logic TDO_IDLE = 1'b0
) (
`ifdef JTAG_TDO_NEGEDGE_EN
  input  logic       tck,
  input  logic       trst,
`endif
  input  tap_state_t state,
  input  logic       ir_tdo,
  input  logic       dr_tdo,
  output logic       tdo,
  output logic       tdo_en
);

  logic tdo_mux;
  logic en_mux;

  always_comb begin
    tdo_mux = TDO_IDLE;
    en_mux  = 1'b0;
    if (state == TAP_SH_IR) begin
      tdo_mux = ir_tdo;
      en_mux  = 1'b1;
    end else if (state == TAP_SH_DR) begin
      tdo_mux = dr_tdo;
      en_mux  = 1'b1;
    end
  end

`ifdef JTAG_TDO_NEGEDGE_EN
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo    <= TDO_IDLE;
      tdo_en <= 1'b0;
    end else begin
      tdo    <= tdo_mux;
      tdo_en <= en_mux;
    end
  end
`else
  assign tdo    = tdo_mux;
  assign tdo_en = en_mux;
`endif

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM on TCK/TMS with Moore-decoded strobes.
// TDO timing selected by JTAG_TDO_NEGEDGE_EN (see tap_tdo_stage).
//
// state    | meaning
// TLR   F  | test-logic reset, test logic held in reset
// RTI   C  | run-test/idle
// SEL_x    | select DR (7) / IR (4) scan branch
// CAP_x    | capture into DR (6) / IR (E)
// SH_x     | shift DR (2) / IR (A), TDO driven
// EX1_x    | exit1 DR (1) / IR (9)
// PAUSE_x  | pause DR (3) / IR (B)
// EX2_x    | exit2 DR (0) / IR (8)
// UPD_x    | update DR (5) / IR (D)
module tap_controller
  import jtag_types_pkg::*;
#(
  parameter int   STATE_W  = TAP_STATE_W,
  parameter logic TDO_IDLE = 1'b0
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               TMS,
  input  logic               ir_tdo,
  input  logic               dr_tdo,
  output logic [STATE_W-1:0] state,
  output logic               tlr_reset,
  output logic               test_reset,
  output logic               ir_capture,
  output logic               ir_shift,
  output logic               ir_update,
  output logic               dr_capture,
  output logic               dr_shift,
  output logic               dr_update,
  output logic               select_ir,
  output logic               TDO,
  output logic               TDO_EN
);

  tap_state_t state_q;
  tap_state_t state_d;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) state_q <= TAP_TLR_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TAP_TLR:      state_d = TMS ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      state_d = TMS ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   state_d = TMS ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_SEL_IR:   state_d = TMS ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_DR:   state_d = TMS ? TAP_EX1_DR   : TAP_SH_DR;
      TAP_SH_DR:    state_d = TMS ? TAP_EX1_DR   : TAP_SH_DR;
      TAP_EX1_DR:   state_d = TMS ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: state_d = TMS ? TAP_EX2_DR   : TAP_PAUSE_DR;
      TAP_EX2_DR:   state_d = TMS ? TAP_UPD_DR   : TAP_SH_DR;
      TAP_UPD_DR:   state_d = TMS ? TAP_SEL_DR   : TAP_RTI;
      TAP_CAP_IR:   state_d = TMS ? TAP_EX1_IR   : TAP_SH_IR;
      TAP_SH_IR:    state_d = TMS ? TAP_EX1_IR   : TAP_SH_IR;
      TAP_EX1_IR:   state_d = TMS ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: state_d = TMS ? TAP_EX2_IR   : TAP_PAUSE_IR;
      TAP_EX2_IR:   state_d = TMS ? TAP_UPD_IR   : TAP_SH_IR;
      TAP_UPD_IR:   state_d = TMS ? TAP_SEL_DR   : TAP_RTI;
      default:      state_d = TAP_TLR_RESET;
    endcase
  end

  // Strobes decode the registered state only, so they are glitch-free for
  // the negedge update latches downstream.
  assign state      = STATE_W'(state_q);
  assign tlr_reset  = (state_q == TAP_TLR);
  assign test_reset = tlr_reset | ~TRST;
  assign ir_capture = (state_q == TAP_CAP_IR);
  assign ir_shift   = (state_q == TAP_SH_IR);
  assign ir_update  = (state_q == TAP_UPD_IR);
  assign dr_capture = (state_q == TAP_CAP_DR);
  assign dr_shift   = (state_q == TAP_SH_DR);
  assign dr_update  = (state_q == TAP_UPD_DR);
  assign select_ir  = state_q inside {TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR,
                                      TAP_PAUSE_IR, TAP_EX2_IR, TAP_UPD_IR};

  tap_tdo_stage #(.TDO_IDLE(TDO_IDLE)) u_tdo_stage (
`ifdef JTAG_TDO_NEGEDGE_EN
    .tck    (TCK),
    .trst   (TRST),
`endif
    .state  (state_q),
    .ir_tdo (ir_tdo),
    .dr_tdo (dr_tdo),
    .tdo    (TDO),
    .tdo_en (TDO_EN)
  );

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: directed scenarios plus random TMS walks
// compared against a transition-table model of the TAP state diagram.
module tb_tap_controller;

  logic       TCK = 1'b0;
  logic       TRST;
  logic       TMS;
  logic       ir_tdo;
  logic       dr_tdo;
  logic [3:0] state;
  logic       tlr_reset, test_reset, ir_capture, ir_shift, ir_update;
  logic       dr_capture, dr_shift, dr_update, select_ir, TDO, TDO_EN;

  tap_controller dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .ir_tdo(ir_tdo), .dr_tdo(dr_tdo),
    .state(state), .tlr_reset(tlr_reset), .test_reset(test_reset),
    .ir_capture(ir_capture), .ir_shift(ir_shift), .ir_update(ir_update),
    .dr_capture(dr_capture), .dr_shift(dr_shift), .dr_update(dr_update),
    .select_ir(select_ir), .TDO(TDO), .TDO_EN(TDO_EN)
  );

  always #5 TCK = ~TCK;

  int checks = 0;
  int errors = 0;

  // Reference diagram: next state indexed by current IEEE code, for TMS=0 / TMS=1.
  logic [3:0] next0 [16];
  logic [3:0] next1 [16];
  logic [3:0] ms;

  function automatic bit is_ir_state(input logic [3:0] s);
    return (s == 4'h4) || (s == 4'hE) || (s == 4'hA) || (s == 4'h9) ||
           (s == 4'hB) || (s == 4'h8) || (s == 4'hD);
  endfunction

  // {tlr_reset, test_reset, ir_cap, ir_sh, ir_upd, dr_cap, dr_sh, dr_upd, select_ir}
  function automatic logic [8:0] exp_strobes(input logic [3:0] s, input logic trst);
    return {s == 4'hF, (s == 4'hF) | ~trst, s == 4'hE, s == 4'hA, s == 4'hD,
            s == 4'h6, s == 4'h2, s == 4'h5, is_ir_state(s)};
  endfunction

  function automatic logic [1:0] exp_tdo(input logic [3:0] s, input logic ir, input logic dr);
    if (s == 4'hA) return {1'b1, ir};
    if (s == 4'h2) return {1'b1, dr};
    return 2'b00;
  endfunction

  function automatic logic [8:0] obs_strobes();
    return {tlr_reset, test_reset, ir_capture, ir_shift, ir_update,
            dr_capture, dr_shift, dr_update, select_ir};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One TCK cycle: drive TMS, check state/strobes after posedge, TDO after negedge.
  task automatic step(input logic tms, input bit rnd_io);
    TMS = tms;
    @(posedge TCK); #1;
    ms = tms ? next1[ms] : next0[ms];
    check("state", 16'(state), 16'(ms));
    check("strobes", 16'(obs_strobes()), 16'(exp_strobes(ms, TRST)));
    if (rnd_io) begin
      ir_tdo = 1'($urandom);
      dr_tdo = 1'($urandom);
    end
    @(negedge TCK); #1;
    check("tdo", 16'({TDO_EN, TDO}), 16'(exp_tdo(ms, ir_tdo, dr_tdo)));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    next0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
              4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    next1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
              4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    TRST = 1'b1; TMS = 1'b1; ir_tdo = 1'b0; dr_tdo = 1'b0;
    #1 TRST = 1'b0;
    #1;
    ms = 4'hF;
    check("reset_state", 16'(state), 16'hF);
    check("reset_strobes", 16'(obs_strobes()), 16'(exp_strobes(4'hF, 1'b0)));
    check("reset_tdo", 16'({TDO_EN, TDO}), 16'h0);
    @(negedge TCK); #1 TRST = 1'b1;

    // TRST asserted in the middle of SHIFT_DR, with no TCK edge in between
    step(0, 1); step(1, 1); step(0, 1); step(0, 1);
    check("t1_in_shdr", 16'(state), 16'h2);
    #2 TRST = 1'b0;
    #1;
    ms = 4'hF;
    check("t1_async_state", 16'(state), 16'hF);
    check("t1_async_strobes", 16'(obs_strobes()), 16'(exp_strobes(4'hF, 1'b0)));
    check("t1_async_tdo_en", 16'(TDO_EN), 16'h0);
    @(negedge TCK); #1;
    check("t1_held_in_reset", 16'(state), 16'hF);
    TRST = 1'b1;

    // Five TMS=1 edges reach TLR from every state; a sixth holds it
    for (int t = 0; t < 16; t++) begin
      reached = (ms == 4'(t));
      for (int n = 0; n < 500 && !reached; n++) begin
        step(1'($urandom), 1);
        reached = (ms == 4'(t));
      end
      if (!reached) begin
        checks++;
        errors++;
        $error("FAIL walk_bound observed=%0h expected=%0h", ms, t);
      end
      for (int k = 0; k < 5; k++) step(1, 1);
      check("t2_five_tms", 16'(state), 16'hF);
      step(1, 1);
      check("t2_sixth_tms", 16'(state), 16'hF);
    end

    // TLR -> CAPTURE_IR -> SHIFT_IR
    step(0, 1); step(1, 1); step(1, 1); step(0, 1);
    check("t3_cap_ir", 16'({state, ir_capture}), 16'({4'hE, 1'b1}));
    step(0, 1);
    check("t3_sh_ir", 16'({state, ir_shift, ir_capture}), 16'({4'hA, 1'b1, 1'b0}));

    // Shift IR five cycles total, then EX1_IR, UPDATE_IR, RTI
    for (int k = 0; k < 4; k++) begin
      step(0, 1);
      check("t4_ir_shift", 16'(ir_shift), 16'h1);
    end
    step(1, 1);
    check("t4_ex1_ir", 16'({state, ir_shift}), 16'({4'h9, 1'b0}));
    step(1, 1);
    check("t4_upd_ir", 16'({state, ir_update}), 16'({4'hD, 1'b1}));
    step(0, 1);
    check("t4_rti", 16'({state, ir_update}), 16'({4'hC, 1'b0}));

    // PAUSE_IR -> EX2_IR -> SHIFT_IR, staying on the IR branch
    step(1, 1); step(1, 1); step(0, 1); step(1, 1); step(0, 1);
    check("t6_pause_ir", 16'({state, select_ir}), 16'({4'hB, 1'b1}));
    step(1, 1);
    check("t6_ex2_ir", 16'({state, select_ir, dr_capture, dr_shift, dr_update}),
          16'({4'h8, 4'b1000}));
    step(0, 1);
    check("t6_sh_ir", 16'({state, select_ir, dr_capture, dr_shift, dr_update}),
          16'({4'hA, 4'b1000}));

    // TDO timing on entry to SHIFT_DR
    step(1, 1); step(1, 1); step(1, 1); step(0, 1);
    check("t5_cap_dr", 16'(state), 16'h6);
    ir_tdo = 1'b0; dr_tdo = 1'b1; TMS = 1'b0;
    @(posedge TCK); #1;
    ms = 4'h2;
    check("t5_sh_dr", 16'(state), 16'h2);
`ifdef JTAG_TDO_NEGEDGE_EN
    check("t5_tdo_before_negedge", 16'({TDO_EN, TDO}), 16'h0);
`else
    check("t5_tdo_immediate", 16'({TDO_EN, TDO}), 16'h3);
`endif
    @(negedge TCK); #1;
    check("t5_tdo_after_negedge", 16'({TDO_EN, TDO}), 16'h3);

    // Long random TMS walk against the model
    for (int n = 0; n < 400; n++) step(1'($urandom), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
